// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter with prioritised redirects and stall handling.
//
// A redirect that arrives while fetch is stalled is captured in pend_tgt and
// applied on the first unstalled cycle. Misaligned non-exception targets are
// replaced by EXC_VECTOR and flagged with a one-cycle addr_error pulse.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   stall             hold PC this cycle
//   branch, zero      conditional branch, taken when both are high
//   jump, jump_reg    absolute / register-indirect jump
//   exception         exception request (highest priority)
//   branch_target, jump_target, jreg_target   redirect destinations
//   pc                current program counter (registered)
//   pc_plus           pc + INCR (combinational, wraps)
//   redirect_pending  a stalled redirect is waiting to be applied
//   addr_error        one-cycle pulse on a rejected misaligned target
module pc_sequencer #(
   parameter int unsigned      WIDTH        = 32,
   parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(32'h0000_0000),
   parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'h0000_0180),
   parameter int unsigned      INCR         = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stall,
   input  logic             branch,
   input  logic             zero,
   input  logic             jump,
   input  logic             jump_reg,
   input  logic             exception,
   input  logic [WIDTH-1:0] branch_target,
   input  logic [WIDTH-1:0] jump_target,
   input  logic [WIDTH-1:0] jreg_target,
   output logic [WIDTH-1:0] pc,
   output logic [WIDTH-1:0] pc_plus,
   output logic             redirect_pending,
   output logic             addr_error
);

   // INCR is a power of two, so INCR-1 masks exactly the low log2(INCR) bits.
   localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(INCR - 1);

   typedef enum logic {StRun, StPend} state_e;

   state_e           state;
   logic [WIDTH-1:0] pend_tgt;

   logic             redirect;
   logic [WIDTH-1:0] raw_tgt;
   logic             misaligned;
   logic [WIDTH-1:0] sel_tgt;

   assign pc_plus = pc + WIDTH'(INCR);

   always_comb begin
      redirect = exception | jump_reg | jump | (branch & zero);
      raw_tgt  = pc_plus;
      if (exception) begin
         raw_tgt = EXC_VECTOR;
      end else if (jump_reg) begin
         raw_tgt = jreg_target;
      end else if (jump) begin
         raw_tgt = jump_target;
      end else if (branch && zero) begin
         raw_tgt = branch_target;
      end
      misaligned = !exception && ((raw_tgt & ALIGN_MASK) != '0);
      sel_tgt    = misaligned ? EXC_VECTOR : raw_tgt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc               <= RESET_VECTOR;
         state            <= StRun;
         pend_tgt         <= '0;
         redirect_pending <= 1'b0;
         addr_error       <= 1'b0;
      end else begin
         addr_error <= 1'b0;
         case (state)
            StRun: begin
               if (!stall) begin
                  pc         <= sel_tgt;
                  addr_error <= misaligned;
               end else if (redirect) begin
                  // Target is already alignment-checked, so applying it later
                  // never raises addr_error a second time.
                  pend_tgt         <= sel_tgt;
                  addr_error       <= misaligned;
                  state            <= StPend;
                  redirect_pending <= 1'b1;
               end
            end
            StPend: begin
               if (stall) begin
                  if (exception) begin
                     pend_tgt <= EXC_VECTOR;
                  end
               end else begin
                  pc               <= exception ? EXC_VECTOR : pend_tgt;
                  state            <= StRun;
                  redirect_pending <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

   localparam logic [31:0] EXC = 32'h0000_0180;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall, branch, zero, jump, jump_reg, exception;
   logic [31:0] branch_target, jump_target, jreg_target;
   logic [31:0] pc, pc_plus;
   logic        redirect_pending, addr_error;

   int tests = 0;
   int fails = 0;

   // Reference model: architectural view (pc, whether a redirect is queued, its target)
   logic [31:0] m_pc;
   bit          m_pend;
   logic [31:0] m_ptgt;
   bit          m_err;

   pc_sequencer dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .stall            (stall),
      .branch           (branch),
      .zero             (zero),
      .jump             (jump),
      .jump_reg         (jump_reg),
      .exception        (exception),
      .branch_target    (branch_target),
      .jump_target      (jump_target),
      .jreg_target      (jreg_target),
      .pc               (pc),
      .pc_plus          (pc_plus),
      .redirect_pending (redirect_pending),
      .addr_error       (addr_error)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag);
      chk({tag, ".pc"}, pc, m_pc);
      chk({tag, ".pc_plus"}, pc_plus, m_pc + 32'd4);
      chk({tag, ".pending"}, {31'd0, redirect_pending}, {31'd0, m_pend});
      chk({tag, ".addr_error"}, {31'd0, addr_error}, {31'd0, m_err});
   endtask

   task automatic clr();
      stall = 0; branch = 0; zero = 0; jump = 0; jump_reg = 0; exception = 0;
      branch_target = 0; jump_target = 0; jreg_target = 0;
   endtask

   task automatic model_reset();
      m_pc = 32'h0; m_pend = 0; m_ptgt = 32'h0; m_err = 0;
   endtask

   // Apply current inputs for one clock edge, advance the model, then compare.
   task automatic cycle(input string tag);
      logic [31:0] tgt;
      bit          redir, bad;
      logic [31:0] n_pc, n_ptgt;
      bit          n_pend, n_err;
      redir = exception || jump_reg || jump || (branch && zero);
      if (exception)              tgt = EXC;
      else if (jump_reg)          tgt = jreg_target;
      else if (jump)              tgt = jump_target;
      else if (branch && zero)    tgt = branch_target;
      else                        tgt = m_pc + 32'd4;
      bad = !exception && (tgt % 4 != 0);
      if (bad) tgt = EXC;
      n_pc = m_pc; n_ptgt = m_ptgt; n_pend = m_pend; n_err = 0;
      if (!m_pend) begin
         if (!stall) begin
            n_pc = tgt; n_err = bad;
         end else if (redir) begin
            n_pend = 1; n_ptgt = tgt; n_err = bad;
         end
      end else if (stall) begin
         if (exception) n_ptgt = EXC;
      end else begin
         n_pc = exception ? EXC : m_ptgt;
         n_pend = 0;
      end
      @(posedge clk);
      #1;
      m_pc = n_pc; m_ptgt = n_ptgt; m_pend = n_pend; m_err = n_err;
      chk_all(tag);
   endtask

   // Asynchronous reset pulse placed between clock edges.
   task automatic pulse_reset(input string tag);
      #2 rst_n = 0;
      #1;
      model_reset();
      chk_all(tag);
      #2 rst_n = 1;
   endtask

   initial begin
      clr();
      rst_n = 0;
      model_reset();
      #3;
      chk("reset.pc", pc, 32'h0);
      chk("reset.pending", {31'd0, redirect_pending}, 32'd0);
      chk("reset.addr_error", {31'd0, addr_error}, 32'd0);
      #8 rst_n = 1;

      // Sequential fetch after reset
      cycle("seq1"); chk("seq1.const", pc, 32'h4);
      cycle("seq2"); chk("seq2.const", pc, 32'h8);
      cycle("seq3"); chk("seq3.const", pc, 32'hC);
      cycle("seq4"); chk("seq4.const", pc, 32'h10);

      // Jump beats taken branch
      branch = 1; zero = 1; branch_target = 32'h40; jump = 1; jump_target = 32'h80;
      cycle("prio"); chk("prio.const", pc, 32'h80);

      // Redirect captured during a 3-cycle stall
      clr(); jump = 1; jump_target = 32'h20;
      cycle("to20");
      stall = 1; jump_target = 32'h100;
      cycle("cap");
      jump = 0;
      cycle("hold1");
      cycle("hold2");
      chk("hold.pc", pc, 32'h20);
      chk("hold.pending", {31'd0, redirect_pending}, 32'd1);
      stall = 0;
      cycle("apply"); chk("apply.pc", pc, 32'h100);
      chk("apply.pending", {31'd0, redirect_pending}, 32'd0);

      // Exception overrides a pending target
      stall = 1; jump = 1; jump_target = 32'h100;
      cycle("cap2");
      jump = 0; exception = 1;
      cycle("excpend");
      exception = 0; stall = 0;
      cycle("excapply"); chk("excapply.pc", pc, EXC);

      // Misaligned register jump
      jump_reg = 1; jreg_target = 32'h102;
      cycle("misal"); chk("misal.pc", pc, EXC);
      chk("misal.err", {31'd0, addr_error}, 32'd1);
      clr();
      cycle("misal2"); chk("misal2.err", {31'd0, addr_error}, 32'd0);

      // Wrap at top of address space
      jump = 1; jump_target = 32'hFFFF_FFFC;
      cycle("top");
      clr();
      cycle("wrap"); chk("wrap.pc", pc, 32'h0);

      // Reset in the middle of a pending redirect
      stall = 1; jump = 1; jump_target = 32'h200;
      cycle("pend3");
      pulse_reset("midreset");
      chk("midreset.pc", pc, 32'h0);
      clr();
      cycle("postreset"); chk("postreset.pc", pc, 32'h4);

      // Randomised traffic
      for (int i = 0; i < 600; i++) begin
         stall     = ($urandom % 10) < 4;
         exception = ($urandom % 16) == 0;
         jump_reg  = ($urandom % 8) == 0;
         jump      = ($urandom % 6) == 0;
         branch    = ($urandom % 4) == 0;
         zero      = $urandom % 2;
         branch_target = $urandom & 32'hFFFF_FFFC;
         jump_target   = $urandom & 32'hFFFF_FFFC;
         jreg_target   = $urandom & 32'hFFFF_FFFC;
         if ($urandom % 8 == 0) branch_target = branch_target | ($urandom % 4);
         if ($urandom % 8 == 0) jump_target   = jump_target | ($urandom % 4);
         if ($urandom % 8 == 0) jreg_target   = jreg_target | ($urandom % 4);
         cycle("rand");
         if ($urandom % 100 == 0) pulse_reset("randreset");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter WIDTH, default 32, PC/target width in bits (>=8).
REQ-002 Parameter RESET_VECTOR, default 32'h0000_0000, PC value after reset.
REQ-003 Parameter EXC_VECTOR, default 32'h0000_0180, exception handler address.
REQ-004 Parameter INCR, default 4, sequential PC increment in bytes (power of two).
REQ-005 clk  input  1  single clock, all state updates on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 stall  input  1  hold PC this cycle (fetch not accepting).
REQ-008 branch  input  1  conditional branch decoded.
REQ-009 zero  input  1  ALU zero flag; branch taken when branch&&zero.
REQ-010 jump  input  1  absolute jump.
REQ-011 jump_reg  input  1  register-indirect jump.
REQ-012 exception  input  1  exception request.
REQ-013 branch_target  input  WIDTH  branch destination.
REQ-014 jump_target  input  WIDTH  jump destination.
REQ-015 jreg_target  input  WIDTH  register jump destination.
REQ-016 pc  output  WIDTH  current program counter (registered).
REQ-017 pc_plus  output  WIDTH  pc+INCR, combinational from pc, modulo 2^WIDTH.
REQ-018 redirect_pending  output  1  a redirect captured during stall awaits application.
REQ-019 addr_error  output  1  one-cycle pulse: misaligned redirect target rejected.

Function
REQ-020 Redirect request priority SHALL be: exception > jump_reg > jump > (branch&&zero) > sequential.
REQ-021 Selected target SHALL be EXC_VECTOR, jreg_target, jump_target, branch_target or pc_plus respectively.
REQ-022 A non-exception target with any of its low log2(INCR) bits set SHALL be misaligned; it is replaced by EXC_VECTOR and addr_error pulses high the following cycle.
REQ-023 FSM states SHALL be RUN and PEND; pending target register pend_tgt WIDTH bits.
REQ-024 RUN, stall=0: pc <= selected target at the clock edge (latency 1 cycle); stay RUN.
REQ-025 RUN, stall=1, no redirect: pc holds; stay RUN.
REQ-026 RUN, stall=1, redirect (exception, jump_reg, jump or taken branch): pc holds, pend_tgt <= selected target (misalignment rule applied), go PEND.
REQ-027 PEND, stall=1: pc holds; only exception overwrites pend_tgt with EXC_VECTOR; other redirects ignored.
REQ-028 PEND, stall=0: pc <= EXC_VECTOR if exception else pend_tgt; non-exception redirects that cycle discarded; go RUN.
REQ-029 redirect_pending SHALL equal (state==PEND), registered.
REQ-030 addr_error SHALL be registered, high exactly one cycle per misaligned capture or apply, including capture during stall.
REQ-031 Sequential increment at max address SHALL wrap to 0 without flag.
REQ-032 branch with zero=0 SHALL be treated as no redirect.

Reset
REQ-033 rst_n low SHALL immediately force pc=RESET_VECTOR, state=RUN, pend_tgt=0, redirect_pending=0, addr_error=0, regardless of clk.
REQ-034 Reset asserted mid-PEND SHALL discard the pending target; first edge after release with stall=0 loads RESET_VECTOR+INCR.

Verification
REQ-035 Reset release, stall=0, no redirect, 3 cycles -> pc 0x0,0x4,0x8,0xC.
REQ-036 pc=0x10, branch=1, zero=1, branch_target=0x40, jump=1, jump_target=0x80 -> pc=0x80 next cycle.
REQ-037 pc=0x20, stall=1, jump=1, jump_target=0x100 for 1 cycle, stall held 3 cycles -> pc stays 0x20, redirect_pending=1; stall=0 -> pc=0x100, redirect_pending=0.
REQ-038 PEND with pend_tgt=0x100, exception=1 during stall -> on release pc=0x180.
REQ-039 jump_reg=1, jreg_target=0x102, stall=0 -> pc=0x180, addr_error=1 one cycle.
REQ-040 pc=0xFFFF_FFFC, stall=0, no redirect -> pc=0x0; rst_n low mid-PEND -> pc=0x0, redirect_pending=0 asynchronously.
